uart_iic_ctrl: RTL and testbench

Command sequencer between the UART byte link and the I2C master in the UART-to-I2C bridge. It parses fixed-format command frames from the UART receiver, issues one register write or read to the I2C master, waits for completion, and returns a 3-byte response frame through the UART transmitter. It owns all sequencing, per-byte and per-transaction timeouts, and status reporting, so neither UART nor I2C engine carries protocol knowledge.

---
 rtl/uart_iic_pkg.sv | 35 +++
 rtl/uart_iic_timer.sv | 40 ++++
 rtl/uart_iic_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_uart_iic_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_iic_pkg.sv
// Shared definitions for the UART-to-I2C command sequencer.
//   state_t    : sequencer states
//   CMD_*      : command codes carried in the second frame byte
//   HDR_*      : frame header bytes (command in, response out)
//   STATUS_*   : status byte returned in the response frame
//   max_u      : helper used to size the shared timeout counter
package uart_iic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_DEV,
        ST_REG,
        ST_DATA,
        ST_ISSUE,
        ST_WAIT,
        ST_RSP0,
        ST_RSP1,
        ST_RSP2
    } state_t;

    localparam logic [7:0] CMD_WR         = 8'h01;
    localparam logic [7:0] CMD_RD         = 8'h02;
    localparam logic [7:0] HDR_CMD        = 8'h55;
    localparam logic [7:0] HDR_RSP        = 8'hAA;
    localparam logic [7:0] STATUS_OK      = 8'h00;
    localparam logic [7:0] STATUS_NACK    = 8'h01;
    localparam logic [7:0] STATUS_BAD_CMD = 8'h02;
    localparam logic [7:0] STATUS_TIMEOUT = 8'h03;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_iic_timer.sv
// Loadable down-counter used for both the inter-byte and the I2C
// transaction timeout.
//   clk, rst  : clock, synchronous active-high reset
//   load      : start counting down from load_val (wins over clear)
//   clear     : disarm the counter
//   load_val  : start value; expired rises load_val+1 cycles after load
//   expired   : armed and count has reached zero
module uart_iic_timer #(
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count;
    logic             armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= load_val;
            armed <= 1'b1;
        end else if (clear) begin
            count <= '0;
            armed <= 1'b0;
        end else if (armed && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Holds at zero once expired so the owner sees a steady level.
    assign expired = armed && (count == '0);

endmodule

// File: rtl/uart_iic_ctrl.sv
// Command sequencer between the UART byte link and the I2C master.
// Parses 0x55,CMD,DEV,REG[,DATA] frames, runs one I2C transaction and
// answers with 0xAA,STATUS,RDATA.
//   clk, rst             : clock, synchronous active-high reset
//   rx_data/rx_valid     : received UART bytes (strobe, no backpressure)
//   tx_data/tx_valid/tx_ready : response bytes to UART TX (valid/ready)
//   iic_start/rw/dev/reg/wdata : transaction request to I2C master
//   iic_done/nack/rdata  : completion from I2C master
//   busy                 : high whenever not IDLE
//
// state  | meaning
// IDLE   | hunting for 0x55 header
// CMD    | waiting for command byte
// DEV    | waiting for device address
// REG    | waiting for register address
// DATA   | waiting for write data
// ISSUE  | pulsing iic_start
// WAIT   | waiting for iic_done or transaction timeout
// RSP0-2 | presenting response bytes 0xAA, STATUS, RDATA
module uart_iic_ctrl
    import uart_iic_pkg::*;
#(
    parameter int unsigned BYTE_TO = 50000,
    parameter int unsigned IIC_TO  = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       iic_start,
    output logic       iic_rw,
    output logic [6:0] iic_dev,
    output logic [7:0] iic_reg,
    output logic [7:0] iic_wdata,
    input  logic       iic_done,
    input  logic       iic_nack,
    input  logic [7:0] iic_rdata,
    output logic       busy
);

    localparam int unsigned TO_MAX = max_u(BYTE_TO, IIC_TO);
    localparam int unsigned TW     = $clog2(TO_MAX + 1);

    state_t          state, next_state;
    logic [7:0]      status_q, rdata_q;
    logic            tmr_clear, tmr_load, tmr_expired;
    logic [TW-1:0]   tmr_val;

    uart_iic_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // A received byte is checked before the timeout so it wins a tie.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_clear  = 1'b0;
        tmr_val    = '0;
        case (state)
            ST_IDLE: begin
                tmr_clear = 1'b1;
                if (rx_valid && (rx_data == HDR_CMD)) begin
                    next_state = ST_CMD;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(BYTE_TO);
                end
            end
            ST_CMD: begin
                if (rx_valid) begin
                    if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                        next_state = ST_DEV;
                        tmr_load   = 1'b1;
                        tmr_val    = TW'(BYTE_TO);
                    end else begin
                        next_state = ST_RSP0;
                        tmr_clear  = 1'b1;
                    end
                end else if (tmr_expired) begin
                    next_state = ST_IDLE;
                end
            end
            ST_DEV: begin
                if (rx_valid) begin
                    next_state = ST_REG;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(BYTE_TO);
                end else if (tmr_expired) begin
                    next_state = ST_IDLE;
                end
            end
            ST_REG: begin
                if (rx_valid) begin
                    next_state = iic_rw ? ST_ISSUE : ST_DATA;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(BYTE_TO);
                end else if (tmr_expired) begin
                    next_state = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    next_state = ST_ISSUE;
                end else if (tmr_expired) begin
                    next_state = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Loaded here so the transaction count starts in WAIT.
                next_state = ST_WAIT;
                tmr_load   = 1'b1;
                tmr_val    = TW'(IIC_TO);
            end
            ST_WAIT: begin
                if (iic_done || tmr_expired) begin
                    next_state = ST_RSP0;
                    tmr_clear  = 1'b1;
                end
            end
            ST_RSP0: if (tx_ready) next_state = ST_RSP1;
            ST_RSP1: if (tx_ready) next_state = ST_RSP2;
            ST_RSP2: if (tx_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iic_rw    <= 1'b0;
            iic_dev   <= '0;
            iic_reg   <= '0;
            iic_wdata <= '0;
            status_q  <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                ST_CMD: if (rx_valid) begin
                    if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                        iic_rw <= (rx_data == CMD_RD);
                    end else begin
                        status_q <= STATUS_BAD_CMD;
                        rdata_q  <= 8'h00;
                    end
                end
                ST_DEV:  if (rx_valid) iic_dev   <= rx_data[6:0];
                ST_REG:  if (rx_valid) iic_reg   <= rx_data;
                ST_DATA: if (rx_valid) iic_wdata <= rx_data;
                ST_WAIT: begin
                    if (iic_done) begin
                        status_q <= iic_nack ? STATUS_NACK : STATUS_OK;
                        rdata_q  <= (iic_rw && !iic_nack) ? iic_rdata : 8'h00;
                    end else if (tmr_expired) begin
                        status_q <= STATUS_TIMEOUT;
                        rdata_q  <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response byte follows the state, so it can only move on a handshake.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            ST_RSP0: begin tx_valid = 1'b1; tx_data = HDR_RSP;  end
            ST_RSP1: begin tx_valid = 1'b1; tx_data = status_q; end
            ST_RSP2: begin tx_valid = 1'b1; tx_data = rdata_q;  end
            default: ;
        endcase
    end

    assign iic_start = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_iic_ctrl.sv
module tb_uart_iic_ctrl;

    localparam int BYTE_TO = 20;
    localparam int IIC_TO  = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       iic_start;
    logic       iic_rw;
    logic [6:0] iic_dev;
    logic [7:0] iic_reg;
    logic [7:0] iic_wdata;
    logic       iic_done;
    logic       iic_nack;
    logic [7:0] iic_rdata;
    logic       busy;

    uart_iic_ctrl #(.BYTE_TO(BYTE_TO), .IIC_TO(IIC_TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .iic_start (iic_start),
        .iic_rw    (iic_rw),
        .iic_dev   (iic_dev),
        .iic_reg   (iic_reg),
        .iic_wdata (iic_wdata),
        .iic_done  (iic_done),
        .iic_nack  (iic_nack),
        .iic_rdata (iic_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observers: launched transactions, accepted response bytes, stall stability.
    int         start_cnt = 0;
    logic       cap_rw;
    logic [6:0] cap_dev;
    logic [7:0] cap_reg, cap_wdata;
    logic [7:0] txq[$];
    int         stall_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) begin
        if (iic_start) begin
            start_cnt++;
            cap_rw    = iic_rw;
            cap_dev   = iic_dev;
            cap_reg   = iic_reg;
            cap_wdata = iic_wdata;
        end
        if (prev_stall && !rst && (tx_valid !== 1'b1 || tx_data !== prev_data))
            stall_err++;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic pulse_done(input logic nack, input logic [7:0] rd);
        iic_done  = 1'b1;
        iic_nack  = nack;
        iic_rdata = rd;
        @(posedge clk);
        #1;
        iic_done  = 1'b0;
        iic_nack  = 1'b0;
        iic_rdata = 8'hEE;
    endtask

    task automatic collect3(input string name);
        int n = 0;
        while (txq.size() < 3 && n < 100) begin
            tick(1);
            n++;
        end
        check({name, "_rsp_count"}, txq.size(), 3);
    endtask

    task automatic check_rsp(input string name, input logic [7:0] st, input logic [7:0] rd);
        if (txq.size() >= 3) begin
            check({name, "_hdr"},    txq[0], 8'hAA);
            check({name, "_status"}, txq[1], st);
            check({name, "_rdata"},  txq[2], rd);
        end
    endtask

    typedef struct {
        string       name;
        logic [39:0] frame;
        int          nbytes;
        bit          exp_start;
        bit          nack;
        logic [7:0]  rdata;
        bit          exp_rw;
        logic [7:0]  exp_dev;
        logic [7:0]  exp_reg;
        logic [7:0]  exp_wdata;
        logic [7:0]  exp_status;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int s0 = start_cnt;
        txq.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < v.nbytes; i++) send_byte(v.frame[39-8*i -: 8]);
        if (v.exp_start) begin
            check({v.name, "_start_now"}, iic_start, 1'b1);
            tick(3);
            pulse_done(v.nack, v.rdata);
            check({v.name, "_valid_after_done"}, tx_valid, 1'b1);
        end else begin
            check({v.name, "_valid_after_cmd"}, tx_valid, 1'b1);
        end
        collect3(v.name);
        check_rsp(v.name, v.exp_status, v.exp_rdata);
        check({v.name, "_starts"}, start_cnt - s0, v.exp_start ? 1 : 0);
        if (v.exp_start) begin
            check({v.name, "_rw"},  cap_rw, v.exp_rw);
            check({v.name, "_dev"}, cap_dev, v.exp_dev);
            check({v.name, "_reg"}, cap_reg, v.exp_reg);
            if (!v.exp_rw) check({v.name, "_wdata"}, cap_wdata, v.exp_wdata);
        end
        tick(1);
        check({v.name, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int s0;
        int n;

        vecs[0] = '{"wr",      40'h55_01_50_10_A5, 5, 1, 0, 8'h00, 0, 8'h50, 8'h10, 8'hA5, 8'h00, 8'h00};
        vecs[1] = '{"rd",      40'h55_02_50_20_00, 4, 1, 0, 8'h3C, 1, 8'h50, 8'h20, 8'h00, 8'h00, 8'h3C};
        vecs[2] = '{"rd_nack", 40'h55_02_50_20_00, 4, 1, 1, 8'h3C, 1, 8'h50, 8'h20, 8'h00, 8'h01, 8'h00};
        vecs[3] = '{"wr_nack", 40'h55_01_D2_33_7E, 5, 1, 1, 8'h00, 0, 8'h52, 8'h33, 8'h7E, 8'h01, 8'h00};
        vecs[4] = '{"bad_cmd", 40'h55_07_00_00_00, 2, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
        vecs[5] = '{"garbage", 40'h12_55_02_11_44, 5, 1, 0, 8'h99, 1, 8'h11, 8'h44, 8'h00, 8'h00, 8'h99};

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        iic_done = 1'b0; iic_nack = 1'b0; iic_rdata = 8'h00;
        tick(3);
        check("rst_tx_data",   tx_data,   8'h00);
        check("rst_tx_valid",  tx_valid,  1'b0);
        check("rst_iic_start", iic_start, 1'b0);
        check("rst_iic_rw",    iic_rw,    1'b0);
        check("rst_iic_dev",   iic_dev,   7'h00);
        check("rst_iic_reg",   iic_reg,   8'h00);
        check("rst_iic_wdata", iic_wdata, 8'h00);
        check("rst_busy",      busy,      1'b0);
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Bad command with stalled TX: bytes arriving during the response are dropped.
        txq.delete();
        tx_ready = 1'b0;
        s0 = start_cnt;
        send_byte(8'h55);
        send_byte(8'h07);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h02);
        check("drop_hold_valid", tx_valid, 1'b1);
        check("drop_hold_data",  tx_data,  8'hAA);
        tx_ready = 1'b1;
        collect3("drop");
        check_rsp("drop", 8'h02, 8'h00);
        tick(2);
        check("drop_idle",   busy, 1'b0);
        check("drop_starts", start_cnt - s0, 0);

        // Byte timeout: BYTE_TO idle cycles still tolerated, one more returns to IDLE.
        txq.delete();
        s0 = start_cnt;
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h50);
        tick(BYTE_TO);
        check("bto_edge_busy", busy, 1'b1);
        send_byte(8'h10);
        tick(BYTE_TO);
        check("bto_still_busy", busy, 1'b1);
        tick(1);
        check("bto_expired_idle", busy, 1'b0);
        tick(5);
        check("bto_no_tx",     txq.size(), 0);
        check("bto_no_start",  start_cnt - s0, 0);

        // Transaction timeout, with a stray iic_done afterwards.
        txq.delete();
        tx_ready = 1'b0;
        send_byte(8'h55);
        send_byte(8'h02);
        send_byte(8'h50);
        send_byte(8'h20);
        tick(IIC_TO + 1);
        check("ito_not_yet", tx_valid, 1'b0);
        tick(1);
        check("ito_valid", tx_valid, 1'b1);
        pulse_done(1'b0, 8'h77);
        tx_ready = 1'b1;
        collect3("ito");
        check_rsp("ito", 8'h03, 8'h00);
        tick(1);

        // Random backpressure on the response.
        txq.delete();
        stall_err = 0;
        tx_ready = 1'b1;
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h50);
        send_byte(8'h10);
        send_byte(8'hA5);
        tick(2);
        pulse_done(1'b0, 8'h00);
        n = 0;
        while (txq.size() < 3 && n < 200) begin
            tx_ready = 1'($urandom_range(0, 1));
            tick(1);
            n++;
        end
        tx_ready = 1'b1;
        tick(5);
        check("bp_rsp_count", txq.size(), 3);
        check_rsp("bp", 8'h00, 8'h00);
        check("bp_stall_stable", stall_err, 0);

        // Reset while waiting on the I2C master.
        txq.delete();
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h50);
        send_byte(8'h10);
        send_byte(8'hA5);
        tick(3);
        check("rw_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        check("rw_busy_after_rst", busy, 1'b0);
        rst = 1'b0;
        tick(1);
        pulse_done(1'b0, 8'h00);
        tick(6);
        check("rw_no_tx",   txq.size(), 0);
        check("rw_idle",    busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "global timeout");
    end

endmodule
